cdb_arbiter: RTL and testbench

- Producer end of the common data bus (CDB).
- Collects completed results from three functional units: ALU/reservation station, branch unit, load/store buffer.
- Buffers each unit's results in its own small FIFO and broadcasts at most one (ROB entry, value) pair per cycle on a single registered CDB.
- The CDB feeds reservation stations, the load/store buffer, the ROB and the regfile; arbitration between units is round-robin.

---
 rtl/cdb_arbiter_pkg.sv | 28 ++
 rtl/cdb_fifo.sv | 64 ++++++
 rtl/cdb_arbiter.sv | 183 ++++++++++++++++++
 tb/tb_cdb_arbiter.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cdb_arbiter_pkg.sv
// cdb_arbiter_pkg
//   Shared constants and types for the common data bus (CDB) producer.
//   Source encodings match the cdb_src_out field: 0=ALU, 1=BR, 2=LSB.
//   ENTRY_NULL is the reserved ROB tag meaning "no dependency".
package cdb_arbiter_pkg;

   localparam logic [1:0] CDB_SRC_ALU = 2'd0;
   localparam logic [1:0] CDB_SRC_BR  = 2'd1;
   localparam logic [1:0] CDB_SRC_LSB = 2'd2;
   localparam int         NUM_SRC     = 3;
   localparam int         ENTRY_NULL  = 0;

   typedef enum logic [1:0] {
      SRC_ALU = CDB_SRC_ALU,
      SRC_BR  = CDB_SRC_BR,
      SRC_LSB = CDB_SRC_LSB
   } cdb_src_e;

   // Next source in round-robin order, modulo 3.
   function automatic cdb_src_e src_inc(input cdb_src_e s);
      case (s)
         SRC_ALU: return SRC_BR;
         SRC_BR:  return SRC_LSB;
         default: return SRC_ALU;
      endcase
   endfunction

endpackage

// File: rtl/cdb_fifo.sv
// cdb_fifo
//   Circular-buffer FIFO holding completed results for one functional unit.
//   Head/tail pointers are log2(DEPTH) bits and wrap naturally, so DEPTH must
//   be a power of two (>= 2). The caller never pushes when full or pops when
//   empty; a simultaneous push and pop leaves the count unchanged.
// Ports
//   clk_in     clock
//   rst_n_in   asynchronous active-low reset (empties the FIFO)
//   flush_in   synchronous empty, overrides push/pop
//   push_in    write data_in at tail
//   pop_in     advance head
//   data_in    entry to write
//   data_out   current head entry (valid when count_out != 0)
//   count_out  number of stored entries, 0..DEPTH
module cdb_fifo #(
   parameter int WIDTH = 36,
   parameter int DEPTH = 4
) (
   input  logic                   clk_in,
   input  logic                   rst_n_in,
   input  logic                   flush_in,
   input  logic                   push_in,
   input  logic                   pop_in,
   input  logic [WIDTH-1:0]       data_in,
   output logic [WIDTH-1:0]       data_out,
   output logic [$clog2(DEPTH):0] count_out
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] head;
   logic [PTR_W-1:0] tail;
   logic [PTR_W:0]   count;

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else if (flush_in) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         if (push_in) tail <= tail + 1'b1;
         if (pop_in)  head <= head + 1'b1;
         case ({push_in, pop_in})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Storage needs no reset: contents are only observed through count.
   always_ff @(posedge clk_in) begin
      if (push_in && !flush_in) mem[tail] <= data_in;
   end

   assign data_out  = mem[head];
   assign count_out = count;

endmodule

// File: rtl/cdb_arbiter.sv
// cdb_arbiter
//   Producer end of the common data bus. Results from the ALU, branch unit
//   and load/store buffer are buffered in one cdb_fifo each; every enabled
//   edge the first non-empty FIFO in round-robin order (starting at rr_ptr)
//   is popped into the registered CDB outputs.
//   Optional feature macro CDB_BYPASS_EN: an incoming result whose FIFO is
//   empty may win arbitration on the same edge it is handshaken and go
//   straight to the output registers without being enqueued.
// Ports
//   clk_in, rst_n_in            clock, asynchronous active-low reset
//   rdy_in                      global enable; low freezes all state
//   flush_in                    mispredict flush; drops buffered and incoming results
//   {alu,br,lsb}_valid_in       result valid per unit
//   {alu,br,lsb}_entry_in       ROB tag (0 = accepted but discarded)
//   {alu,br,lsb}_value_in       result value
//   {alu,br,lsb}_ready_out      FIFO can accept this cycle
//   cdb_valid_out/entry/value   registered broadcast
//   cdb_src_out                 broadcast source: 0=ALU, 1=BR, 2=LSB
module cdb_arbiter
   import cdb_arbiter_pkg::*;
#(
   parameter int ENTRY_W    = 4,
   parameter int FIFO_DEPTH = 4
) (
   input  logic               clk_in,
   input  logic               rst_n_in,
   input  logic               rdy_in,
   input  logic               flush_in,
   input  logic               alu_valid_in,
   input  logic [ENTRY_W-1:0] alu_entry_in,
   input  logic [31:0]        alu_value_in,
   output logic               alu_ready_out,
   input  logic               br_valid_in,
   input  logic [ENTRY_W-1:0] br_entry_in,
   input  logic [31:0]        br_value_in,
   output logic               br_ready_out,
   input  logic               lsb_valid_in,
   input  logic [ENTRY_W-1:0] lsb_entry_in,
   input  logic [31:0]        lsb_value_in,
   output logic               lsb_ready_out,
   output logic               cdb_valid_out,
   output logic [ENTRY_W-1:0] cdb_entry_out,
   output logic [31:0]        cdb_value_out,
   output logic [1:0]         cdb_src_out
);

   localparam int DATA_W = ENTRY_W + 32;
   localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;

   logic                rst_done;
   logic [NUM_SRC-1:0]  valid_vec;
   logic [NUM_SRC-1:0]  ready_vec;
   logic [NUM_SRC-1:0]  hs;
   logic [NUM_SRC-1:0]  tag_ok;
   logic [NUM_SRC-1:0]  empty;
   logic [NUM_SRC-1:0]  cand;
   logic [NUM_SRC-1:0]  push;
   logic [NUM_SRC-1:0]  pop;
   logic [ENTRY_W-1:0]  entry_vec [NUM_SRC];
   logic [31:0]         value_vec [NUM_SRC];
   logic [DATA_W-1:0]   head_vec  [NUM_SRC];
   logic [CNT_W-1:0]    count_vec [NUM_SRC];

   cdb_src_e            rr_ptr;
   cdb_src_e            winner;
   cdb_src_e            scan;
   logic                grant;
   logic                bypass_sel;
   logic [DATA_W-1:0]   win_data;

   assign valid_vec    = {lsb_valid_in, br_valid_in, alu_valid_in};
   assign entry_vec[0] = alu_entry_in;
   assign entry_vec[1] = br_entry_in;
   assign entry_vec[2] = lsb_entry_in;
   assign value_vec[0] = alu_value_in;
   assign value_vec[1] = br_value_in;
   assign value_vec[2] = lsb_value_in;

   // Holds the ready outputs low until the first edge after reset release.
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) rst_done <= 1'b0;
      else           rst_done <= 1'b1;
   end

   // Ready depends on the registered count only; a pop on the same edge
   // does not free a slot for an incoming result.
   always_comb begin
      ready_vec = '0;
      hs        = '0;
      tag_ok    = '0;
      empty     = '0;
      cand      = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         ready_vec[i] = rst_done && rdy_in && (count_vec[i] < CNT_W'(FIFO_DEPTH));
         hs[i]        = valid_vec[i] && ready_vec[i] && !flush_in;
         tag_ok[i]    = (entry_vec[i] != ENTRY_W'(ENTRY_NULL));
         empty[i]     = (count_vec[i] == '0);
`ifdef CDB_BYPASS_EN
         cand[i]      = !empty[i] || (hs[i] && tag_ok[i]);
`else
         cand[i]      = !empty[i];
`endif
      end
   end

   assign alu_ready_out = ready_vec[0];
   assign br_ready_out  = ready_vec[1];
   assign lsb_ready_out = ready_vec[2];

   always_comb begin
      grant  = 1'b0;
      winner = SRC_ALU;
      scan   = rr_ptr;
      for (int k = 0; k < NUM_SRC; k++) begin
         if (!grant && cand[scan]) begin
            grant  = 1'b1;
            winner = scan;
         end
         scan = src_inc(scan);
      end
   end

   // A winner with an empty FIFO can only be an incoming bypass result.
`ifdef CDB_BYPASS_EN
   assign bypass_sel = grant && empty[winner];
`else
   assign bypass_sel = 1'b0;
`endif

   always_comb begin
      pop  = '0;
      push = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         pop[i]  = grant && !bypass_sel && (int'(winner) == i) && rdy_in && !flush_in;
         push[i] = hs[i] && tag_ok[i] && !(bypass_sel && (int'(winner) == i));
      end
   end

   always_comb begin
      win_data = head_vec[winner];
      if (bypass_sel) win_data = {entry_vec[winner], value_vec[winner]};
   end

   for (genvar i = 0; i < NUM_SRC; i++) begin : g_fifo
      cdb_fifo #(
         .WIDTH (DATA_W),
         .DEPTH (FIFO_DEPTH)
      ) u_fifo (
         .clk_in    (clk_in),
         .rst_n_in  (rst_n_in),
         .flush_in  (flush_in),
         .push_in   (push[i]),
         .pop_in    (pop[i]),
         .data_in   ({entry_vec[i], value_vec[i]}),
         .data_out  (head_vec[i]),
         .count_out (count_vec[i])
      );
   end

   // Flush wins over the enable; rr_ptr and the held payload survive it.
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         cdb_valid_out <= 1'b0;
         cdb_entry_out <= '0;
         cdb_value_out <= '0;
         cdb_src_out   <= '0;
         rr_ptr        <= SRC_ALU;
      end else if (flush_in) begin
         cdb_valid_out <= 1'b0;
      end else if (rdy_in) begin
         if (grant) begin
            cdb_valid_out <= 1'b1;
            cdb_entry_out <= win_data[DATA_W-1:32];
            cdb_value_out <= win_data[31:0];
            cdb_src_out   <= winner;
            rr_ptr        <= src_inc(winner);
         end else begin
            cdb_valid_out <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter
//   Drives cdb_arbiter with directed scenarios and randomized traffic and
//   compares every cycle against a queue-level model of the bus.
//   Build with CDB_BYPASS_EN defined to exercise the bypass variant.
module tb_cdb_arbiter;

   localparam int ENTRY_W = 4;
   localparam int DEPTH   = 4;

   logic               clk = 1'b0;
   logic               rst_n = 1'b0;
   logic               rdy_in = 1'b1;
   logic               flush_in = 1'b0;
   logic               alu_valid_in = 1'b0, br_valid_in = 1'b0, lsb_valid_in = 1'b0;
   logic [ENTRY_W-1:0] alu_entry_in = '0, br_entry_in = '0, lsb_entry_in = '0;
   logic [31:0]        alu_value_in = '0, br_value_in = '0, lsb_value_in = '0;
   logic               alu_ready_out, br_ready_out, lsb_ready_out;
   logic               cdb_valid_out;
   logic [ENTRY_W-1:0] cdb_entry_out;
   logic [31:0]        cdb_value_out;
   logic [1:0]         cdb_src_out;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   cdb_arbiter #(.ENTRY_W(ENTRY_W), .FIFO_DEPTH(DEPTH)) dut (
      .clk_in        (clk),
      .rst_n_in      (rst_n),
      .rdy_in        (rdy_in),
      .flush_in      (flush_in),
      .alu_valid_in  (alu_valid_in),
      .alu_entry_in  (alu_entry_in),
      .alu_value_in  (alu_value_in),
      .alu_ready_out (alu_ready_out),
      .br_valid_in   (br_valid_in),
      .br_entry_in   (br_entry_in),
      .br_value_in   (br_value_in),
      .br_ready_out  (br_ready_out),
      .lsb_valid_in  (lsb_valid_in),
      .lsb_entry_in  (lsb_entry_in),
      .lsb_value_in  (lsb_value_in),
      .lsb_ready_out (lsb_ready_out),
      .cdb_valid_out (cdb_valid_out),
      .cdb_entry_out (cdb_entry_out),
      .cdb_value_out (cdb_value_out),
      .cdb_src_out   (cdb_src_out)
   );

   task automatic chk(input string nm, input logic [35:0] act, input logic [35:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, want %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // Each source is a plain ordered list of {entry,value}; index 0 is oldest.
   logic [35:0] mq [3][DEPTH];
   int          mcnt [3] = '{0, 0, 0};
   int          m_rr = 0;
   bit          m_rst_done = 0;
   logic        e_valid = 1'b0;
   logic [3:0]  e_entry = '0;
   logic [31:0] e_value = '0;
   logic [1:0]  e_src = '0;
   bit          m_vin [3];
   logic [3:0]  m_ein [3];
   logic [31:0] m_din [3];
   bit          m_hs [3];
   int          m_win;
   bit          m_byp;

   function automatic bit m_ready(input int s);
      return m_rst_done && (mcnt[s] < DEPTH) && rdy_in;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int s = 0; s < 3; s++) mcnt[s] = 0;
         m_rr = 0; m_rst_done = 0;
         e_valid = 0; e_entry = '0; e_value = '0; e_src = '0;
      end else begin
         m_vin = '{alu_valid_in, br_valid_in, lsb_valid_in};
         m_ein = '{alu_entry_in, br_entry_in, lsb_entry_in};
         m_din = '{alu_value_in, br_value_in, lsb_value_in};
         for (int s = 0; s < 3; s++) m_hs[s] = m_vin[s] && m_ready(s) && !flush_in;
         if (flush_in) begin
            for (int s = 0; s < 3; s++) mcnt[s] = 0;
            e_valid = 0;
         end else if (rdy_in) begin
            m_win = -1; m_byp = 0;
            for (int k = 0; k < 3; k++) begin
               int s;
               s = (m_rr + k) % 3;
               if (m_win < 0) begin
                  if (mcnt[s] > 0) m_win = s;
`ifdef CDB_BYPASS_EN
                  else if (m_hs[s] && m_ein[s] != 0) begin m_win = s; m_byp = 1; end
`endif
               end
            end
            if (m_win >= 0) begin
               e_valid = 1; e_src = 2'(m_win);
               if (m_byp) begin
                  e_entry = m_ein[m_win]; e_value = m_din[m_win];
               end else begin
                  {e_entry, e_value} = mq[m_win][0];
                  for (int j = 0; j < DEPTH - 1; j++) mq[m_win][j] = mq[m_win][j+1];
                  mcnt[m_win]--;
               end
               m_rr = (m_win + 1) % 3;
            end else begin
               e_valid = 0;
            end
            for (int s = 0; s < 3; s++)
               if (m_hs[s] && m_ein[s] != 0 && !(m_byp && m_win == s)) begin
                  mq[s][mcnt[s]] = {m_ein[s], m_din[s]};
                  mcnt[s]++;
               end
         end
         m_rst_done = 1;
      end
   end

   // Cycle-by-cycle comparison against the model.
   always @(negedge clk) begin
      chk("cdb_valid", 36'(cdb_valid_out), 36'(e_valid));
      chk("cdb_entry", 36'(cdb_entry_out), 36'(e_entry));
      chk("cdb_value", 36'(cdb_value_out), 36'(e_value));
      chk("cdb_src",   36'(cdb_src_out),   36'(e_src));
      chk("alu_ready", 36'(alu_ready_out), 36'(m_ready(0)));
      chk("br_ready",  36'(br_ready_out),  36'(m_ready(1)));
      chk("lsb_ready", 36'(lsb_ready_out), 36'(m_ready(2)));
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      alu_valid_in = 0; br_valid_in = 0; lsb_valid_in = 0;
      flush_in = 0; rdy_in = 1;
   endtask

   task automatic drv(input int s, input logic [3:0] e, input logic [31:0] v);
      case (s)
         0: begin alu_valid_in = 1; alu_entry_in = e; alu_value_in = v; end
         1: begin br_valid_in  = 1; br_entry_in  = e; br_value_in  = v; end
         default: begin lsb_valid_in = 1; lsb_entry_in = e; lsb_value_in = v; end
      endcase
   endtask

   task automatic chk_bc(input string nm, input logic [3:0] e, input logic [31:0] v, input logic [1:0] s);
      chk({nm, "_valid"}, 36'(cdb_valid_out), 36'd1);
      chk({nm, "_entry"}, 36'(cdb_entry_out), 36'(e));
      chk({nm, "_value"}, 36'(cdb_value_out), 36'(v));
      chk({nm, "_src"},   36'(cdb_src_out),   36'(s));
   endtask

   initial begin
      idle();
      repeat (3) tick();
      chk("rst_ready", 36'({alu_ready_out, br_ready_out, lsb_ready_out}), 36'd0);
      chk("rst_valid", 36'(cdb_valid_out), 36'd0);
      rst_n = 1;
      chk("rel_ready_pre", 36'({alu_ready_out, br_ready_out, lsb_ready_out}), 36'd0);
      tick();
      chk("rel_ready_post", 36'({alu_ready_out, br_ready_out, lsb_ready_out}), 36'h7);

`ifndef CDB_BYPASS_EN
      // Round-robin: all three at once, rr_ptr=0.
      drv(0, 4'd1, 32'hA); drv(1, 4'd2, 32'hB); drv(2, 4'd5, 32'hC);
      tick(); idle();
      tick(); chk_bc("rr0", 4'd1, 32'hA, 2'd0);
      tick(); chk_bc("rr1", 4'd2, 32'hB, 2'd1);
      tick(); chk_bc("rr2", 4'd5, 32'hC, 2'd2);
      chk("rr_ptr_after", 36'(dut.rr_ptr), 36'd0);
      tick(); chk("rr_idle", 36'(cdb_valid_out), 36'd0);

      // Single result: minimum two-edge latency.
      drv(0, 4'd3, 32'h11);
      tick(); idle(); chk("single_e1", 36'(cdb_valid_out), 36'd0);
      tick(); chk_bc("single", 4'd3, 32'h11, 2'd0);
      tick(); chk("single_e3", 36'(cdb_valid_out), 36'd0);

      // One BR result moves rr_ptr to 2.
      drv(1, 4'd4, 32'h44);
      tick(); idle();
      tick(); chk_bc("br1", 4'd4, 32'h44, 2'd1);
      tick();

      // Full BR FIFO while LSB keeps the arbiter busy.
      for (int i = 0; i < 7; i++) begin
         drv(1, 4'(i + 1), 32'h100 + 32'(i));
         drv(2, 4'(i + 8), 32'h200 + 32'(i));
         tick();
         if (i == 5) begin
            chk("full_br_ready", 36'(br_ready_out), 36'd0);
            chk("full_lsb_ready", 36'(lsb_ready_out), 36'd1);
         end
         if (i == 6) chk("full_br_ready_after_pop", 36'(br_ready_out), 36'd1);
      end
      idle();
      repeat (12) tick();

      // Flush with three buffered and one incoming result.
      drv(0, 4'd6, 32'h61); drv(1, 4'd7, 32'h71); drv(2, 4'd8, 32'h81);
      tick(); idle();
      drv(0, 4'd9, 32'h91); flush_in = 1;
      tick(); idle();
      chk("flush_valid", 36'(cdb_valid_out), 36'd0);
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("flush_quiet", 36'(cdb_valid_out), 36'd0);
      end

      // Tag 0 then a three-cycle stall.
      drv(2, 4'd0, 32'h55);
      tick(); idle();
      tick(); chk("tag0_none", 36'(cdb_valid_out), 36'd0);
      rdy_in = 0; drv(0, 4'd10, 32'hAA);
      for (int i = 0; i < 3; i++) begin
         #1 chk("stall_alu_ready", 36'(alu_ready_out), 36'd0);
         tick();
         chk("stall_valid", 36'(cdb_valid_out), 36'd0);
      end
      rdy_in = 1;
      tick(); idle(); chk("stall_r1", 36'(cdb_valid_out), 36'd0);
      tick(); chk_bc("stall_r2", 4'd10, 32'hAA, 2'd0);
      tick();
`else
      // Bypass: incoming result with empty FIFOs broadcasts after one edge.
      drv(0, 4'd7, 32'h77);
      tick(); idle();
      chk_bc("bypass", 4'd7, 32'h77, 2'd0);
      chk("bypass_count", 36'(dut.g_fifo[0].u_fifo.count), 36'd0);
      tick(); chk("bypass_e2", 36'(cdb_valid_out), 36'd0);
`endif

      // Randomized traffic with stalls, flushes and occasional resets.
      for (int c = 0; c < 3000; c++) begin
         alu_valid_in = ($urandom_range(0, 99) < 45);
         br_valid_in  = ($urandom_range(0, 99) < 45);
         lsb_valid_in = ($urandom_range(0, 99) < 45);
         alu_entry_in = 4'($urandom_range(0, 15));
         br_entry_in  = 4'($urandom_range(0, 15));
         lsb_entry_in = 4'($urandom_range(0, 15));
         alu_value_in = $urandom; br_value_in = $urandom; lsb_value_in = $urandom;
         rdy_in   = ($urandom_range(0, 99) < 88);
         flush_in = ($urandom_range(0, 99) < 3);
         if ($urandom_range(0, 999) < 4) begin
            rst_n = 0;
            tick();
            rst_n = 1;
         end
         tick();
      end
      idle();
      repeat (20) tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
